// File: rtl/tristate_bus_arbiter_if.sv
// Shared tristate bus control interface.
//   req   : one request bit per driver, driven by the requesters
//   gnt   : one-hot registered grant, zero when nobody owns the bus
//   oe    : tristate output enable per driver, identical to gnt
//   owner : index of the current owner, meaningful only while busy=1
//   busy  : an owner holds the bus
//   turn  : bus turnaround in progress, all drivers disabled
// Handshake: a requester holds req[i] high for as long as it wants the bus.
// It may drive the wire only in cycles where oe[i]=1. It releases the bus by
// dropping req[i]. A requester that sees gnt[i] fall while req[i] is still
// high has been preempted, and it keeps competing as long as it keeps
// requesting.
interface tristate_bus_arbiter_if #(
  parameter int N = 4
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] oe;
  logic [W-1:0] owner;
  logic         busy;
  logic         turn;

  // master: the arbiter side
  modport master (input req, output gnt, oe, owner, busy, turn);
  // slave: the requester side
  modport slave (output req, input gnt, oe, owner, busy, turn);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for N drivers sharing one tristate bus wire.
// Every change of owner passes through TURN_CYC cycles in which no driver is
// enabled. An owner that has held the bus for MAX_HOLD cycles is preempted
// when another driver is waiting.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   bus       : tristate_bus_arbiter_if.master (req in; gnt/oe/owner/busy/turn out)
//   dbg_state : current FSM state (0 IDLE, 1 GRANT, 2 TURN)
// All outputs come from flops. req only affects next-state logic.
// TURN_CYC must be at least 1.
module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  tristate_bus_arbiter_if.master bus,
  output logic [1:0]            dbg_state
);
  localparam int W  = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  owner_q, owner_n;
  logic [W-1:0]  ptr_q, ptr_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [TW-1:0] tcnt_q, tcnt_n;
  logic [N-1:0]  gnt_q, gnt_n;
  logic          busy_q, busy_n;
  logic          turn_q, turn_n;

  logic          win_found;
  logic [W-1:0]  win_idx;
  logic [N-1:0]  owner_mask;
  logic          others_req;

  // Round-robin search that starts at ptr and wraps from N-1 to 0.
  // The first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && bus.req[(int'(ptr_q) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = W'((int'(ptr_q) + k) % N);
      end
    end
  end

  assign owner_mask = {{(N-1){1'b0}}, 1'b1} << owner_q;
  assign others_req = |(bus.req & ~owner_mask);

  always_comb begin
    state_n = state;
    owner_n = owner_q;
    ptr_n   = ptr_q;
    hold_n  = hold_q;
    tcnt_n  = tcnt_q;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n = GRANT;
          owner_n = win_idx;
          hold_n  = HW'(1);
        end
      end
      GRANT: begin
        // The owner releases the bus, or it has used up its hold budget
        // while someone else is waiting.
        if (!bus.req[owner_q] || ((hold_q == HW'(MAX_HOLD)) && others_req)) begin
          state_n = TURN;
          ptr_n   = (owner_q == W'(N - 1)) ? '0 : owner_q + 1'b1;
          hold_n  = '0;
          tcnt_n  = TW'(1);
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_n = hold_q + 1'b1;
        end
      end
      TURN: begin
        // Only the last turnaround cycle looks at req. Earlier cycles just
        // count, so a request that comes and goes there is ignored.
        if (tcnt_q == TW'(TURN_CYC)) begin
          tcnt_n = '0;
          if (win_found) begin
            state_n = GRANT;
            owner_n = win_idx;
            hold_n  = HW'(1);
          end else begin
            state_n = IDLE;
          end
        end else begin
          tcnt_n = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state and registered, so gnt/oe
  // change exactly on the clock edge.
  always_comb begin
    gnt_n  = (state_n == GRANT) ? ({{(N-1){1'b0}}, 1'b1} << owner_n) : '0;
    busy_n = (state_n == GRANT);
    turn_n = (state_n == TURN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      tcnt_q  <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      turn_q  <= 1'b0;
    end else begin
      state   <= state_n;
      owner_q <= owner_n;
      ptr_q   <= ptr_n;
      hold_q  <= hold_n;
      tcnt_q  <= tcnt_n;
      gnt_q   <= gnt_n;
      busy_q  <= busy_n;
      turn_q  <= turn_n;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.oe    = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.turn  = turn_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Testbench for tristate_bus_arbiter with N=4, MAX_HOLD=4, TURN_CYC=1.
// Directed vectors come from a table. Hand-written sequences cover the
// preemption and saturation cases. A long random run is checked against a
// behavioural model and against bus-safety properties.
module tb_tristate_bus_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int TURN_CYC = 1;
  // A preempted owner waits through its own turnaround and then up to
  // N-1 other owners, each with a full hold and a turnaround.
  localparam int STARVE_LIMIT = (N - 1) * (MAX_HOLD + TURN_CYC) + TURN_CYC;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  tristate_bus_arbiter_if #(.N(N)) bus_if ();

  tristate_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // Scoreboard. Packed expectation: {owner[1:0], turn, busy, gnt[3:0]}.
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [3:0] prev_gnt = '0;
  int wait_cnt[N];

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       busy;
    logic       turn;
  } vec_t;
  vec_t tbl[19];

  // Behavioural reference model (0 idle, 1 grant, 2 turn)
  int m_state = 0, m_owner = 0, m_ptr = 0, m_hold = 0, m_tcnt = 0;

  function automatic int pick(input logic [3:0] q, input int p);
    for (int k = 0; k < N; k++) begin
      if (q[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [7:0] pack(input logic [3:0] g, input logic b, input logic t);
    logic [1:0] o;
    o = 2'd0;
    for (int i = 0; i < N; i++) if (b && g[i]) o = 2'(i);
    return {o, t, b, g};
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q, output logic [7:0] e);
    logic [3:0] g;
    if (r) begin
      m_state = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_tcnt = 0;
    end else begin
      case (m_state)
        0: if (q != 4'b0) begin
          m_owner = pick(q, m_ptr); m_state = 1; m_hold = 1;
        end
        1: begin
          if (!q[m_owner] || (m_hold == MAX_HOLD && (q & ~(4'b0001 << m_owner)) != 4'b0)) begin
            m_ptr = (m_owner + 1) % N; m_state = 2; m_tcnt = 1; m_hold = 0;
          end else if (m_hold < MAX_HOLD) begin
            m_hold = m_hold + 1;
          end
        end
        default: begin
          if (m_tcnt == TURN_CYC) begin
            if (q != 4'b0) begin
              m_owner = pick(q, m_ptr); m_state = 1; m_hold = 1;
            end else begin
              m_state = 0;
            end
          end else begin
            m_tcnt = m_tcnt + 1;
          end
        end
      endcase
    end
    g = (m_state == 1) ? (4'b0001 << m_owner) : 4'b0000;
    e = pack(g, m_state == 1, m_state == 2);
  endtask

  // Compare one sampled cycle against the scoreboard and the bus properties.
  task automatic check_outputs();
    logic [7:0] exp_v, act_v;
    act_v = {bus_if.busy ? bus_if.owner : 2'd0, bus_if.turn, bus_if.busy, bus_if.gnt};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs at %0t: owner/turn/busy/gnt got %b required %b", $time, act_v, exp_v);
      end
    end
    checks++;
    if (bus_if.oe !== bus_if.gnt || $countones(bus_if.oe) > 1) begin
      errors++;
      $display("FAIL oe_onehot at %0t: oe=%b gnt=%b", $time, bus_if.oe, bus_if.gnt);
    end
    checks++;
    if (prev_gnt != 4'b0 && bus_if.gnt != 4'b0 && prev_gnt != bus_if.gnt) begin
      errors++;
      $display("FAIL turnaround at %0t: gnt %b -> %b with no idle cycle", $time, prev_gnt, bus_if.gnt);
    end
    prev_gnt = bus_if.gnt;
    for (int i = 0; i < N; i++) begin
      if (rst || !bus_if.req[i] || bus_if.gnt[i]) wait_cnt[i] = 0;
      else wait_cnt[i] = wait_cnt[i] + 1;
      if (wait_cnt[i] == STARVE_LIMIT + 1) begin
        checks++;
        errors++;
        $display("FAIL starvation at %0t: req[%0d] waited %0d cycles, limit %0d", $time, i, wait_cnt[i], STARVE_LIMIT);
      end
    end
  endtask

  // Driver. Drives on the falling edge and pushes the expectation. When
  // use_tab is set the hand-written expectation is pushed; otherwise the
  // model's is. The model is always stepped so it stays in sync.
  task automatic cycle(input logic r, input logic [3:0] q, input logic use_tab, input logic [7:0] tab_e);
    logic [7:0] m_e;
    @(negedge clk);
    rst = r;
    bus_if.req = q;
    model_step(r, q, m_e);
    exp_q.push_back(use_tab ? tab_e : m_e);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic hold_seq(input logic [3:0] q, input logic [3:0] g, input logic b, input logic t, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, q, 1'b1, pack(g, b, t));
  endtask

  initial begin
    logic [3:0] cur;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    bus_if.req = 4'b0;

    //           rst   req      gnt      busy  turn
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0101, 4'b0001, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'b0101, 4'b0001, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0110, 4'b0010, 1'b1, 1'b0}; // ptr=3 wraps to 1
    tbl[11] = '{1'b0, 4'b0110, 4'b0010, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 4'b0110, 4'b0000, 1'b0, 1'b0}; // reset mid-GRANT
    tbl[13] = '{1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0}; // ptr back to 0
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0}; // reset mid-TURN
    tbl[16] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0}; // ptr now 2

    for (int i = 0; i < 19; i++)
      cycle(tbl[i].rst, tbl[i].req, 1'b1, pack(tbl[i].gnt, tbl[i].busy, tbl[i].turn));

    // Two constant requesters alternate, with preemption at hold=4.
    hold_seq(4'b0011, 4'b0001, 1'b1, 1'b0, 4);
    hold_seq(4'b0011, 4'b0000, 1'b0, 1'b1, 1);
    hold_seq(4'b0011, 4'b0010, 1'b1, 1'b0, 4);
    hold_seq(4'b0011, 4'b0000, 1'b0, 1'b1, 1);
    hold_seq(4'b0011, 4'b0001, 1'b1, 1'b0, 2);
    hold_seq(4'b0000, 4'b0000, 1'b0, 1'b1, 1);
    hold_seq(4'b0000, 4'b0000, 1'b0, 1'b0, 1);

    // A lone requester keeps the bus past MAX_HOLD.
    hold_seq(4'b1000, 4'b1000, 1'b1, 1'b0, 10);
    hold_seq(4'b0000, 4'b0000, 1'b0, 1'b1, 1);
    hold_seq(4'b0000, 4'b0000, 1'b0, 1'b0, 1);

    // Random traffic with sticky request bits and rare resets.
    cur = 4'b0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
      cycle($urandom_range(0, 999) == 0, cur, 1'b0, 8'h00);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
